// File: rtl/sequence_game_engine.sv
// Sequence memory game: LFSR-generated symbols, valid/ready playback, guess checking.
// Optional macro SEQ_SEED_LOAD_EN adds seed_load/seed_in for runtime LFSR reseeding.
module sequence_game_engine #(
    parameter int unsigned       SYM_W   = 3,
    parameter int unsigned       MAX_LEN = 5,
    parameter int unsigned       LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
`ifdef SEQ_SEED_LOAD_EN
    input  logic                          seed_load,
    input  logic [LFSR_W-1:0]             seed_in,
`endif
    output logic [SYM_W-1:0]              sym_out,
    output logic                          sym_valid,
    input  logic                          sym_ready,
    input  logic [SYM_W-1:0]              guess_in,
    input  logic                          guess_valid,
    output logic [$clog2(MAX_LEN+1)-1:0]  level,
    output logic                          busy,
    output logic                          round_pass,
    output logic                          game_over,
    output logic                          game_win
);

    localparam int unsigned LVL_W = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, FILL, PLAY, INPUT} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [LVL_W-1:0]   level_n;
    logic [LFSR_W-1:0]  lfsr, lfsr_step;
    logic [SYM_W-1:0]   seq [MAX_LEN];
    logic               fill_we;
    logic               pass_n, over_n, win_n;
    logic               round_last, fill_last;

    // Galois step; a nonzero state can never map to zero with a top-bit tap
    always_comb begin
        lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
`ifdef SEQ_SEED_LOAD_EN
            if (seed_load) begin
                lfsr <= (seed_in == '0) ? SEED : seed_in;
            end else begin
                lfsr <= lfsr_step;
            end
`else
            lfsr <= lfsr_step;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seq[i] <= '0;
            end
        end else if (fill_we) begin
            seq[idx] <= lfsr[SYM_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            level      <= '0;
            round_pass <= 1'b0;
            game_over  <= 1'b0;
            game_win   <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            level      <= level_n;
            round_pass <= pass_n;
            game_over  <= over_n;
            game_win   <= win_n;
        end
    end

    always_comb begin
        round_last = (LVL_W'(idx) == (level - LVL_W'(1)));
        fill_last  = (idx == IDX_W'(MAX_LEN - 1));
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        level_n = level;
        fill_we = 1'b0;
        pass_n  = 1'b0;
        over_n  = 1'b0;
        win_n   = 1'b0;
        // start wins over any handshake or guess in the same cycle
        if (start) begin
            state_n = FILL;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: ;
                FILL: begin
                    fill_we = 1'b1;
                    if (fill_last) begin
                        idx_n   = '0;
                        level_n = LVL_W'(1);
                        state_n = PLAY;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
                PLAY: begin
                    if (sym_ready) begin
                        if (round_last) begin
                            idx_n   = '0;
                            state_n = INPUT;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end
                end
                INPUT: begin
                    if (guess_valid) begin
                        if (guess_in != seq[idx]) begin
                            over_n  = 1'b1;
                            idx_n   = '0;
                            state_n = IDLE;
                        end else if (!round_last) begin
                            idx_n = idx + IDX_W'(1);
                        end else if (level == LVL_W'(MAX_LEN)) begin
                            win_n   = 1'b1;
                            idx_n   = '0;
                            state_n = IDLE;
                        end else begin
                            pass_n  = 1'b1;
                            level_n = level + LVL_W'(1);
                            idx_n   = '0;
                            state_n = PLAY;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        sym_valid = (state == PLAY);
        sym_out   = (state == PLAY) ? seq[idx] : '0;
        busy      = (state != IDLE);
    end

endmodule
